fpnew_divsqrt_mant_iter: RTL and testbench
==========================================

// Module: fpnew_divsqrt_mant_iter
// PURPOSE
//  Iterative radix-2 mantissa divide / square-root engine: responder side of the start/ready/done/kill protocol
//  that the divsqrt wrapper FSM drives. Accepts normalized mantissas, produces one result bit per cycle,
//  returns truncated quotient/root plus sticky bit for the caller's rounding stage. No exponent/special-case logic.
// PARAMETERS
//  MANT_BITS  53                       mantissa width incl. hidden bit (M); operands normalized, MSB=1
//  QW         MANT_BITS+2 (localparam) max result bits (mantissa + guard + round)
//  IW         $clog2(QW+1) (localparam) width of iteration-count input
// PORTS
//  clk_i         in   1    clock
//  rst_i         in   1    synchronous, active-high reset
//  div_start_i   in   1    start divide a/b; honored only when ready_o=1
//  sqrt_start_i  in   1    start sqrt of a; honored only when ready_o=1
//  sqrt_odd_i    in   1    sqrt only: radicand R = a<<1 when 1, R = a when 0 (odd-exponent fix)
//  operand_a_i   in   M    dividend / radicand mantissa
//  operand_b_i   in   M    divisor mantissa (ignored for sqrt)
//  num_iter_i    in   IW   result bits n to produce; 0 or >QW treated as QW
//  kill_i        in   1    abort any operation
//  ready_o       out  1    engine accepts a start this cycle
//  done_o        out  1    one-cycle pulse: quotient_o/sticky_o valid
//  quotient_o    out  QW   result, right-aligned in low n bits, upper bits 0
//  sticky_o      out  1    1 iff discarded remainder nonzero (result inexact)
// BEHAVIOUR
//  Reset: state IDLE; ready_o=1, done_o=0, quotient_o=0, sticky_o=0.
//  States: IDLE -> BUSY on accepted start; BUSY -> DONE after n iterations; DONE -> IDLE (or BUSY on new start).
//  ready_o=1 in IDLE and DONE, 0 in BUSY. Start in DONE cycle is accepted (back-to-back ops, no bubble).
//  Start accepted = (div_start_i|sqrt_start_i) & ready_o & ~kill_i; operands, n, op, odd latched that cycle.
//  Both starts high: divide wins. Starts in BUSY are ignored (no queuing).
//  Latency: start accepted in cycle t -> iterations on edges ending t+1..t+n -> done_o=1 in cycle t+n+1 only.
//  Divide: Q = floor(a*2^(n-1)/b) (fits n bits since a,b normalized); sticky = (a*2^(n-1) mod b) != 0.
//  Sqrt:   Q = floor(sqrt(R*2^(2n-M-1))) with exact rational value; sticky = 1 iff Q^2 != that value.
//  Restoring / non-restoring internal remainder sized to never overflow (>= M+3 bits); result bit-exact to above.
//  b==0 (divide): Q forced to 2^n-1, sticky = (a!=0); caller flags DZ separately.
//  quotient_o/sticky_o update only at end of an operation; held stable from done_o until next accepted start
//  completes (caller may sit in HOLD reading them). Mid-operation outputs keep previous result.
//  kill_i: any state -> IDLE next cycle; no done_o for the killed op; ready_o=1 next cycle; kill with start
//  in same cycle -> start dropped. Held result outputs unchanged by kill.
//  rst_i mid-operation: same as reset values next cycle, no done_o.
//  Unknown/illegal state encodings recover to IDLE.
// TESTING (MANT_BITS=8 unless noted)
//  div a=0x80,b=0xC0,n=10 -> done_o at t+11, quotient_o=0x155, sticky_o=1; ready_o=0 t+1..t+10.
//  sqrt a=0x80,odd=0,n=10 -> quotient_o=0x200, sticky_o=0; odd=1 -> quotient_o=0x2D4, sticky_o=1.
//  div a=0xC0,b=0x80,n=0 (->QW=10) -> quotient_o=0x300, sticky_o=0; b=0 -> 0x3FF, sticky 1.
//  back-to-back: 2nd start in done cycle -> accepted, 2nd done exactly n+1 cycles later; 1st result held till then.
//  kill at t+4 of div -> no done_o, ready_o=1 at t+5, quotient_o keeps prior value; kill+start same cycle -> ignored.
//  random M=53 ops vs. big-integer model (n in 1..55, both odd values), plus rst_i asserted mid-op -> reset values.

Source files
------------

// File: rtl/fpnew_divsqrt_mant_iter.sv
// Radix-2 iterative mantissa divide / square-root engine, one result bit per cycle.
// Returns a truncated quotient/root right-aligned in n bits plus a sticky bit for rounding.
//
// state | meaning
// IDLE  | waiting for a start, ready
// BUSY  | producing one result bit per cycle
// DONE  | result valid pulse, ready for a back-to-back start
module fpnew_divsqrt_mant_iter #(
  parameter  int unsigned MANT_BITS = 53,
  localparam int unsigned QW        = MANT_BITS + 2,
  localparam int unsigned IW        = $clog2(QW + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 div_start_i,
  input  logic                 sqrt_start_i,
  input  logic                 sqrt_odd_i,
  input  logic [MANT_BITS-1:0] operand_a_i,
  input  logic [MANT_BITS-1:0] operand_b_i,
  input  logic [IW-1:0]        num_iter_i,
  input  logic                 kill_i,
  output logic                 ready_o,
  output logic                 done_o,
  output logic [QW-1:0]        quotient_o,
  output logic                 sticky_o
);

  localparam int unsigned RMW  = MANT_BITS + 5;
  localparam int unsigned RADW = MANT_BITS + 2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]           r_state;
  logic [1:0]           w_state_nxt;
  logic                 w_ready;
  logic                 w_done;
  logic                 w_start;
  logic                 w_last;

  logic                 r_is_sqrt;
  logic                 r_bzero;
  logic                 r_a_nz;
  logic [MANT_BITS-1:0] r_div;
  logic [RMW-1:0]       r_rem;
  logic [RADW-1:0]      r_rad;
  logic [QW-1:0]        r_q;
  logic [IW-1:0]        r_cnt;
  logic [IW-1:0]        r_n;
  logic [QW-1:0]        r_quot;
  logic                 r_sticky;

  logic [IW-1:0]        w_n;
  logic [MANT_BITS:0]   w_radicand;
  logic [RMW-1:0]       w_cur;
  logic [RMW-1:0]       w_sub;
  logic                 w_ge;
  logic [RMW-1:0]       w_diff;
  logic [QW-1:0]        w_q_nxt;
  logic [QW-1:0]        w_ones;

  assign w_start = (div_start_i | sqrt_start_i) & w_ready & ~kill_i;
  assign w_last  = (r_cnt == IW'(1));

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_nxt = S_BUSY;
      S_BUSY:  if (w_last)  w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = w_start ? S_BUSY : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (kill_i) w_state_nxt = S_IDLE;
  end

  always_comb begin
    w_ready = 1'b0;
    w_done  = 1'b0;
    case (r_state)
      S_IDLE:  w_ready = 1'b1;
      S_DONE:  begin w_ready = 1'b1; w_done = 1'b1; end
      default: w_ready = 1'b0;
    endcase
  end

  // Zero or out-of-range iteration counts mean "full precision".
  assign w_n = (num_iter_i == '0 || num_iter_i > IW'(QW)) ? IW'(QW) : num_iter_i;
  assign w_radicand = sqrt_odd_i ? {operand_a_i, 1'b0} : {1'b0, operand_a_i};

  // Sqrt consumes the radicand two bits per step, trial value is 4*root+1.
  assign w_cur   = r_is_sqrt ? {r_rem[RMW-3:0], r_rad[RADW-1 -: 2]} : r_rem;
  assign w_sub   = r_is_sqrt ? RMW'({r_q, 2'b01}) : RMW'(r_div);
  assign w_ge    = (w_cur >= w_sub);
  assign w_diff  = w_ge ? (w_cur - w_sub) : w_cur;
  assign w_q_nxt = {r_q[QW-2:0], w_ge};
  assign w_ones  = {QW{1'b1}} >> (IW'(QW) - r_n);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_is_sqrt <= 1'b0;
      r_bzero   <= 1'b0;
      r_a_nz    <= 1'b0;
      r_div     <= '0;
      r_rem     <= '0;
      r_rad     <= '0;
      r_q       <= '0;
      r_cnt     <= '0;
      r_n       <= '0;
      r_quot    <= '0;
      r_sticky  <= 1'b0;
    end else if (w_start) begin
      r_is_sqrt <= ~div_start_i;
      r_bzero   <= (operand_b_i == '0);
      r_a_nz    <= |operand_a_i;
      r_div     <= operand_b_i;
      r_rem     <= div_start_i ? RMW'(operand_a_i) : '0;
      r_rad     <= {w_radicand, 1'b0};
      r_q       <= '0;
      r_cnt     <= w_n;
      r_n       <= w_n;
    end else if (r_state == S_BUSY && !kill_i) begin
      r_q   <= w_q_nxt;
      r_rem <= r_is_sqrt ? w_diff : {w_diff[RMW-2:0], 1'b0};
      r_rad <= r_rad << 2;
      r_cnt <= r_cnt - IW'(1);
      if (w_last) begin
        if (r_is_sqrt) begin
          r_quot   <= w_q_nxt;
          r_sticky <= (|w_diff) | (|r_rad[RADW-3:0]);
        end else if (r_bzero) begin
          r_quot   <= w_ones;
          r_sticky <= r_a_nz;
        end else begin
          r_quot   <= w_q_nxt;
          r_sticky <= |w_diff;
        end
      end
    end
  end

  assign ready_o    = w_ready;
  assign done_o     = w_done;
  assign quotient_o = r_quot;
  assign sticky_o   = r_sticky;

endmodule

// File: tb/tb_fpnew_divsqrt_mant_iter.sv
// Bench for the iterative divide/sqrt engine: directed M=8 scenarios plus random M=53
// operations checked against a big-integer model.
module tb_fpnew_divsqrt_mant_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic       d8_div, d8_sqrt, d8_odd, d8_kill;
  logic [7:0] d8_a, d8_b;
  logic [3:0] d8_n;
  logic       d8_ready, d8_done, d8_sticky;
  logic [9:0] d8_q;

  logic        e_div, e_sqrt, e_odd, e_kill;
  logic [52:0] e_a, e_b;
  logic [5:0]  e_n;
  logic        e_ready, e_done, e_sticky;
  logic [54:0] e_q;

  int checks = 0;
  int errors = 0;

  fpnew_divsqrt_mant_iter #(.MANT_BITS(8)) u_dut8 (
    .clk_i(clk), .rst_i(rst), .div_start_i(d8_div), .sqrt_start_i(d8_sqrt),
    .sqrt_odd_i(d8_odd), .operand_a_i(d8_a), .operand_b_i(d8_b), .num_iter_i(d8_n),
    .kill_i(d8_kill), .ready_o(d8_ready), .done_o(d8_done), .quotient_o(d8_q),
    .sticky_o(d8_sticky)
  );

  fpnew_divsqrt_mant_iter #(.MANT_BITS(53)) u_dut53 (
    .clk_i(clk), .rst_i(rst), .div_start_i(e_div), .sqrt_start_i(e_sqrt),
    .sqrt_odd_i(e_odd), .operand_a_i(e_a), .operand_b_i(e_b), .num_iter_i(e_n),
    .kill_i(e_kill), .ready_o(e_ready), .done_o(e_done), .quotient_o(e_q),
    .sticky_o(e_sticky)
  );

  // Reference: Q = floor(a*2^(n-1)/b); b==0 gives all ones.
  function automatic void model_div(input logic [127:0] a, input logic [127:0] b, input int n,
                                    output logic [127:0] q, output logic s);
    logic [127:0] num;
    if (b == 0) begin
      q = (128'd1 << n) - 128'd1;
      s = (a != 0);
    end else begin
      num = a << (n - 1);
      q = num / b;
      s = ((num % b) != 0);
    end
  endfunction

  // Reference: largest Q with Q^2 <= R*2^(2n-m-1), compared exactly as integers.
  function automatic void model_sqrt(input logic [127:0] a, input logic odd, input int n, input int m,
                                     output logic [127:0] q, output logic s);
    logic [127:0] r, rs, t;
    int e, ls;
    r  = odd ? (a << 1) : a;
    e  = 2 * n - m - 1;
    rs = (e >= 0) ? (r << e) : r;
    ls = (e >= 0) ? 0 : -e;
    q  = 0;
    for (int bi = n - 1; bi >= 0; bi--) begin
      t = q | (128'd1 << bi);
      if (((t * t) << ls) <= rs) q = t;
    end
    s = (((q * q) << ls) != rs);
  endfunction

  task automatic issue8(input logic is_div, input logic is_sqrt, input logic odd,
                        input logic [7:0] a, input logic [7:0] b, input logic [3:0] n,
                        output int lat, output logic [9:0] q, output logic s, output int busy_ready);
    @(negedge clk);
    d8_div = is_div; d8_sqrt = is_sqrt; d8_odd = odd; d8_a = a; d8_b = b; d8_n = n;
    lat = -1; busy_ready = 0; q = '0; s = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      d8_div = 1'b0; d8_sqrt = 1'b0;
      if (d8_done) begin lat = c; q = d8_q; s = d8_sticky; break; end
      if (d8_ready) busy_ready++;
    end
  endtask

  task automatic issue53(input logic is_div, input logic odd, input logic [52:0] a,
                         input logic [52:0] b, input logic [5:0] n,
                         output int lat, output logic [54:0] q, output logic s);
    @(negedge clk);
    e_div = is_div; e_sqrt = ~is_div; e_odd = odd; e_a = a; e_b = b; e_n = n;
    lat = -1; q = '0; s = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      e_div = 1'b0; e_sqrt = 1'b0;
      if (e_done) begin lat = c; q = e_q; s = e_sticky; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (d8_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", d8_ready); end
    checks++; if (d8_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", d8_done); end
    checks++; if (d8_q !== 10'h0) begin errors++; $display("FAIL reset_quot: got %h expected 000", d8_q); end
    checks++; if (d8_sticky !== 1'b0) begin errors++; $display("FAIL reset_sticky: got %b expected 0", d8_sticky); end
    checks++; if (e_ready !== 1'b1 || e_q !== 55'h0) begin errors++; $display("FAIL reset_m53: got ready=%b q=%h expected ready=1 q=0", e_ready, e_q); end
  endtask

  task automatic test_div_basic();
    int lat, br; logic [9:0] q; logic s;
    issue8(1'b1, 1'b0, 1'b0, 8'h80, 8'hC0, 4'd10, lat, q, s, br);
    checks++; if (lat != 11) begin errors++; $display("FAIL div_latency: got %0d expected 11", lat); end
    checks++; if (br != 0) begin errors++; $display("FAIL div_busy_ready: got %0d ready cycles expected 0", br); end
    checks++; if (q !== 10'h155) begin errors++; $display("FAIL div_quot: got %h expected 155", q); end
    checks++; if (s !== 1'b1) begin errors++; $display("FAIL div_sticky: got %b expected 1", s); end
  endtask

  task automatic test_sqrt();
    int lat, br; logic [9:0] q; logic s;
    issue8(1'b0, 1'b1, 1'b0, 8'h80, 8'h00, 4'd10, lat, q, s, br);
    checks++; if (lat != 11) begin errors++; $display("FAIL sqrt_latency: got %0d expected 11", lat); end
    checks++; if (q !== 10'h200 || s !== 1'b0) begin errors++; $display("FAIL sqrt_even: got %h/%b expected 200/0", q, s); end
    issue8(1'b0, 1'b1, 1'b1, 8'h80, 8'h00, 4'd10, lat, q, s, br);
    checks++; if (q !== 10'h2D4 || s !== 1'b1) begin errors++; $display("FAIL sqrt_odd: got %h/%b expected 2d4/1", q, s); end
    // Both starts high: divide takes priority.
    issue8(1'b1, 1'b1, 1'b0, 8'hC0, 8'h80, 4'd10, lat, q, s, br);
    checks++; if (q !== 10'h300 || s !== 1'b0) begin errors++; $display("FAIL both_starts: got %h/%b expected 300/0", q, s); end
  endtask

  task automatic test_div_full_n();
    int lat, br; logic [9:0] q; logic s;
    issue8(1'b1, 1'b0, 1'b0, 8'hC0, 8'h80, 4'd0, lat, q, s, br);
    checks++; if (lat != 11) begin errors++; $display("FAIL n0_latency: got %0d expected 11", lat); end
    checks++; if (q !== 10'h300 || s !== 1'b0) begin errors++; $display("FAIL n0_div: got %h/%b expected 300/0", q, s); end
    issue8(1'b1, 1'b0, 1'b0, 8'hC0, 8'h00, 4'd0, lat, q, s, br);
    checks++; if (q !== 10'h3FF || s !== 1'b1) begin errors++; $display("FAIL div_by_zero: got %h/%b expected 3ff/1", q, s); end
    issue8(1'b1, 1'b0, 1'b0, 8'hC0, 8'h80, 4'd15, lat, q, s, br);
    checks++; if (lat != 11 || q !== 10'h300) begin errors++; $display("FAIL n_over_qw: got lat=%0d q=%h expected 11/300", lat, q); end
  endtask

  task automatic test_back_to_back();
    int lat, br, lat2, held_bad; logic [9:0] q, q2; logic s, s2;
    issue8(1'b1, 1'b0, 1'b0, 8'h80, 8'hC0, 4'd10, lat, q, s, br);
    checks++; if (d8_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_in_done: got %b expected 1", d8_ready); end
    d8_sqrt = 1'b1; d8_odd = 1'b1; d8_a = 8'h80; d8_n = 4'd5;
    lat2 = -1; held_bad = 0; q2 = '0; s2 = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      d8_sqrt = 1'b0;
      if (d8_done) begin lat2 = c; q2 = d8_q; s2 = d8_sticky; break; end
      if (d8_q !== 10'h155 || d8_sticky !== 1'b1) held_bad++;
    end
    checks++; if (lat2 != 6) begin errors++; $display("FAIL b2b_latency: got %0d expected 6", lat2); end
    checks++; if (held_bad != 0) begin errors++; $display("FAIL b2b_held: got %0d changed cycles expected 0", held_bad); end
    checks++; if (q2 !== 10'h016 || s2 !== 1'b1) begin errors++; $display("FAIL b2b_result: got %h/%b expected 016/1", q2, s2); end
  endtask

  task automatic test_kill();
    int dones;
    @(negedge clk);
    d8_div = 1'b1; d8_a = 8'h80; d8_b = 8'hC0; d8_n = 4'd10;
    @(negedge clk);
    d8_div = 1'b0;
    repeat (3) @(negedge clk);
    d8_kill = 1'b1;
    @(negedge clk);
    d8_kill = 1'b0;
    checks++; if (d8_ready !== 1'b1 || d8_done !== 1'b0) begin errors++; $display("FAIL kill_state: got ready=%b done=%b expected 1/0", d8_ready, d8_done); end
    checks++; if (d8_q !== 10'h016 || d8_sticky !== 1'b1) begin errors++; $display("FAIL kill_hold: got %h/%b expected 016/1", d8_q, d8_sticky); end
    dones = 0;
    repeat (20) begin @(negedge clk); if (d8_done) dones++; end
    checks++; if (dones != 0) begin errors++; $display("FAIL kill_no_done: got %0d done pulses expected 0", dones); end
    @(negedge clk);
    d8_div = 1'b1; d8_kill = 1'b1;
    @(negedge clk);
    d8_div = 1'b0; d8_kill = 1'b0;
    checks++; if (d8_ready !== 1'b1) begin errors++; $display("FAIL kill_start_dropped: got ready=%b expected 1", d8_ready); end
    dones = 0;
    repeat (20) begin @(negedge clk); if (d8_done) dones++; end
    checks++; if (dones != 0 || d8_q !== 10'h016) begin errors++; $display("FAIL kill_start_idle: got %0d dones q=%h expected 0/016", dones, d8_q); end
  endtask

  task automatic test_random();
    int lat, n_eff; logic [54:0] q; logic s; logic [127:0] mq; logic ms;
    logic is_div, odd; logic [52:0] a, b; logic [5:0] n;
    for (int i = 0; i < 40; i++) begin
      is_div = 1'($urandom_range(0, 1));
      odd    = 1'($urandom_range(0, 1));
      a = {1'b1, 20'($urandom), 32'($urandom)};
      b = {1'b1, 20'($urandom), 32'($urandom)};
      if ($urandom_range(0, 3) == 0) a[39:0] = '0;
      if ($urandom_range(0, 7) == 0) b = a;
      if ($urandom_range(0, 11) == 0) b = '0;
      n = 6'($urandom_range(0, 63));
      n_eff = (n == 0 || n > 55) ? 55 : int'(n);
      if (is_div) model_div(128'(a), 128'(b), n_eff, mq, ms);
      else        model_sqrt(128'(a), odd, n_eff, 53, mq, ms);
      issue53(is_div, odd, a, b, n, lat, q, s);
      checks++; if (lat != n_eff + 1) begin errors++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", i, lat, n_eff + 1); end
      checks++; if (128'(q) !== mq) begin errors++; $display("FAIL rand_quot[%0d] div=%b n=%0d: got %h expected %h", i, is_div, n_eff, q, mq); end
      checks++; if (s !== ms) begin errors++; $display("FAIL rand_sticky[%0d] div=%b n=%0d: got %b expected %b", i, is_div, n_eff, s, ms); end
    end
  endtask

  task automatic test_reset_midop();
    int dones;
    @(negedge clk);
    e_div = 1'b1; e_a = 53'h1F_0000_0000_1234; e_b = 53'h18_0000_0000_0001; e_n = 6'd30;
    @(negedge clk);
    e_div = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (e_ready !== 1'b1 || e_done !== 1'b0) begin errors++; $display("FAIL rst_midop_state: got ready=%b done=%b expected 1/0", e_ready, e_done); end
    checks++; if (e_q !== 55'h0 || e_sticky !== 1'b0) begin errors++; $display("FAIL rst_midop_result: got %h/%b expected 0/0", e_q, e_sticky); end
    dones = 0;
    repeat (40) begin @(negedge clk); if (e_done) dones++; end
    checks++; if (dones != 0) begin errors++; $display("FAIL rst_midop_no_done: got %0d done pulses expected 0", dones); end
  endtask

  initial begin
    rst = 1'b1;
    d8_div = 1'b0; d8_sqrt = 1'b0; d8_odd = 1'b0; d8_kill = 1'b0; d8_a = '0; d8_b = '0; d8_n = '0;
    e_div = 1'b0; e_sqrt = 1'b0; e_odd = 1'b0; e_kill = 1'b0; e_a = '0; e_b = '0; e_n = '0;
    test_reset();
    test_div_basic();
    test_sqrt();
    test_div_full_n();
    test_back_to_back();
    test_kill();
    test_random();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
